// File: rtl/alarm_sequencer_if.sv
// Purpose : bundles the time, alarm-setting, button and status signals of the alarm sequencer.
// Ports   : slave side (sequencer) takes time/alarm/button levels, drives state/ringer/speaker/snooze status;
//           master side (surrounding clock logic or bench) is the mirror image.
interface alarm_sequencer_if;
   logic       sec_tick;
   logic [4:0] cur_hour;
   logic [5:0] cur_min;
   logic [4:0] alm_hour;
   logic [5:0] alm_min;
   logic       alarm_en;
   logic       snooze_btn;
   logic       stop_btn;
   logic [1:0] state;
   logic       ringer;
   logic       speaker_out;
   logic       snoozing;
   logic [2:0] snooze_cnt;

   modport slave (
      input  sec_tick, cur_hour, cur_min, alm_hour, alm_min,
             alarm_en, snooze_btn, stop_btn,
      output state, ringer, speaker_out, snoozing, snooze_cnt
   );

   modport master (
      output sec_tick, cur_hour, cur_min, alm_hour, alm_min,
             alarm_en, snooze_btn, stop_btn,
      input  state, ringer, speaker_out, snoozing, snooze_cnt
   );
endinterface

// File: rtl/alarm_sequencer.sv
// Purpose : decides when the alarm speaker sounds; runs the ring / snooze / stop sequence and beep-gates the speaker.
// Latency : every output is a flop, updated one clk after the triggering input is sampled.
// Ports   : clk, reset_n (async active-low); bus (slave) carries time, alarm setting, buttons, and status outputs.
//           No backpressure: inputs are levels or single-cycle pulses that are always accepted.
module alarm_sequencer #(
   parameter int RING_TIMEOUT_SEC = 60,
   parameter int SNOOZE_SEC       = 300,
   parameter int MAX_SNOOZE       = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   alarm_sequencer_if.slave   bus
);

   localparam int RW = (RING_TIMEOUT_SEC > 2) ? $clog2(RING_TIMEOUT_SEC) : 1;
   localparam int SW = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;
   localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT_SEC - 1);
   localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SEC - 1);
   localparam logic [2:0]    SNZ_MAX   = 3'(MAX_SNOOZE);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      RINGING = 2'd2,
      SNOOZE  = 2'd3
   } state_t;

   state_t        state_q, state_n;
   logic [RW-1:0] ring_cnt_q, ring_cnt_n;
   logic [SW-1:0] snz_timer_q, snz_timer_n;
   logic [2:0]    snooze_cnt_q, snooze_cnt_n;
   logic          beep_q, beep_n;
   logic          ringer_q, ringer_n;
   logic          speaker_q, speaker_n;
   logic          snoozing_q, snoozing_n;

   // Edge-detect delay flops run in every state so a level held across
   // a state change never produces a second rising edge.
   logic match, match_d, match_rise;
   logic snooze_d, snooze_rise;
   logic stop_d, stop_rise;

   assign match       = (bus.cur_hour == bus.alm_hour) && (bus.cur_min == bus.alm_min);
   assign match_rise  = match & ~match_d;
   assign snooze_rise = bus.snooze_btn & ~snooze_d;
   assign stop_rise   = bus.stop_btn & ~stop_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         ring_cnt_q   <= '0;
         snz_timer_q  <= '0;
         snooze_cnt_q <= '0;
         beep_q       <= 1'b0;
         ringer_q     <= 1'b0;
         speaker_q    <= 1'b0;
         snoozing_q   <= 1'b0;
         match_d      <= 1'b0;
         snooze_d     <= 1'b0;
         stop_d       <= 1'b0;
      end else begin
         state_q      <= state_n;
         ring_cnt_q   <= ring_cnt_n;
         snz_timer_q  <= snz_timer_n;
         snooze_cnt_q <= snooze_cnt_n;
         beep_q       <= beep_n;
         ringer_q     <= ringer_n;
         speaker_q    <= speaker_n;
         snoozing_q   <= snoozing_n;
         match_d      <= match;
         snooze_d     <= bus.snooze_btn;
         stop_d       <= bus.stop_btn;
      end
   end

   // Priority inside a cycle: alarm_en low, stop, snooze, sec_tick.
   always_comb begin
      state_n      = state_q;
      ring_cnt_n   = ring_cnt_q;
      snz_timer_n  = snz_timer_q;
      snooze_cnt_n = snooze_cnt_q;
      beep_n       = beep_q;

      if (!bus.alarm_en) begin
         state_n      = IDLE;
         ring_cnt_n   = '0;
         snz_timer_n  = '0;
         snooze_cnt_n = '0;
         beep_n       = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // match_rise is not consulted here: enabling inside the
               // matching minute must not ring.
               state_n = ARMED;
            end
            ARMED: begin
               if (match_rise) begin
                  state_n      = RINGING;
                  ring_cnt_n   = '0;
                  beep_n       = 1'b1;
                  snooze_cnt_n = '0;
               end
            end
            RINGING: begin
               if (stop_rise) begin
                  state_n      = ARMED;
                  snooze_cnt_n = '0;
               end else if (snooze_rise && (snooze_cnt_q < SNZ_MAX)) begin
                  state_n      = SNOOZE;
                  snooze_cnt_n = snooze_cnt_q + 3'd1;
                  snz_timer_n  = '0;
               end else if (bus.sec_tick) begin
                  // Snooze press at the limit falls through to here, so a
                  // coincident tick is still honoured.
                  if (ring_cnt_q == RING_LAST) begin
                     state_n      = ARMED;
                     snooze_cnt_n = '0;
                  end else begin
                     ring_cnt_n = ring_cnt_q + RW'(1);
                     beep_n     = ~beep_q;
                  end
               end
            end
            SNOOZE: begin
               if (stop_rise) begin
                  state_n      = ARMED;
                  snooze_cnt_n = '0;
               end else if (bus.sec_tick) begin
                  if (snz_timer_q == SNZ_LAST) begin
                     state_n    = RINGING;
                     ring_cnt_n = '0;
                     beep_n     = 1'b1;
                  end else begin
                     snz_timer_n = snz_timer_q + SW'(1);
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end

      // Outputs are derived from next-state values so they are registered
      // alongside state and never lag it.
      ringer_n   = (state_n == RINGING);
      speaker_n  = ringer_n & beep_n;
      snoozing_n = (state_n == SNOOZE);
   end

   assign bus.state       = state_q;
   assign bus.ringer      = ringer_q;
   assign bus.speaker_out = speaker_q;
   assign bus.snoozing    = snoozing_q;
   assign bus.snooze_cnt  = snooze_cnt_q;

endmodule
